// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, state type and motion encoding for the sprite animator
//   Keycodes recognised, FSM state enum, motion base values and the motion encode helper.
package sprite_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'd80;
    localparam logic [7:0] KEY_RIGHT = 8'd79;
    localparam logic [7:0] KEY_UP    = 8'd82;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        JUMP = 2'd2
    } state_e;

    localparam logic [3:0] MOT_IDLE = 4'd0;
    localparam logic [3:0] MOT_WALK = 4'd2;
    localparam logic [3:0] MOT_JUMP = 4'd10;

    // Sprite index: idle/jump pick by facing, walk adds a 4-frame block per facing.
    function automatic logic [3:0] motion_of(state_e s, logic facing, logic [1:0] frame);
        logic [3:0] m;
        case (s)
            WALK:    m = MOT_WALK + {1'b0, facing, 2'b00} + {2'b00, frame};
            JUMP:    m = MOT_JUMP + {3'b000, facing};
            default: m = MOT_IDLE + {3'b000, facing};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/anim_counter.sv
// rtl/anim_counter.sv - modulo-N counter with clear, enable and terminal-count flag
//   clk_i : clock
//   rst_i : asynchronous active-high reset, count -> 0
//   clr_i : synchronous clear (wins over enable)
//   en_i  : advance one step, wrapping N-1 -> 0
//   tc_o  : high while the count sits at N-1
module anim_counter #(
    parameter int N = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] count_q;

    assign tc_o = (count_q == W'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= tc_o ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/sprite_state.sv
// rtl/sprite_state.sv - keycode driven player sprite animation state machine
//   Clk     : clock, one update per frame tick
//   Reset   : asynchronous active-high reset
//   Keycode : current HID keycode (0 = no key)
//   motion  : registered 4-bit sprite index for the color mapper
module sprite_state
    import sprite_pkg::*;
#(
    parameter int FRAME_DIV   = 4,
    parameter int JUMP_CYCLES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Keycode,
    output logic [3:0] motion
);

    state_e     state_q, state_d;
    logic       facing_q, facing_d;
    logic [1:0] frame_q, frame_d;
    logic [3:0] motion_q;

    logic div_adv, div_tc;
    logic jmp_run, jmp_tc;

    logic key_left, key_right, key_up;

    assign key_left  = (Keycode == KEY_LEFT);
    assign key_right = (Keycode == KEY_RIGHT);
    assign key_up    = (Keycode == KEY_UP);

    always_comb begin
        state_d  = state_q;
        facing_d = facing_q;
        frame_d  = frame_q;
        div_adv  = 1'b0;
        jmp_run  = 1'b0;

        if (state_q == JUMP && !jmp_tc) begin
            // Mid-jump: keys are ignored, only the jump timer runs.
            jmp_run = 1'b1;
        end else begin
            // IDLE, WALK, or the last jump cycle (which behaves like IDLE,
            // since state_q == JUMP never matches the "keep walking" test).
            if (key_left || key_right) begin
                if (state_q == WALK && facing_q == key_left) begin
                    div_adv = 1'b1;
                    if (div_tc) begin
                        frame_d = frame_q + 2'd1;
                    end
                end else begin
                    state_d  = WALK;
                    facing_d = key_left;
                    frame_d  = 2'd0;
                end
            end else if (key_up) begin
                state_d = JUMP;
                frame_d = 2'd0;
            end else begin
                state_d = IDLE;
                frame_d = 2'd0;
            end
        end
    end

    // Divider only runs while a walk continues in the same direction;
    // every other transition leaves it at zero for the next walk.
    anim_counter #(.N(FRAME_DIV)) u_walk_div (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (!div_adv),
        .en_i  (div_adv),
        .tc_o  (div_tc)
    );

    // Held at zero outside a jump, so entering JUMP always starts from 0.
    anim_counter #(.N(JUMP_CYCLES)) u_jump_tmr (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (!jmp_run),
        .en_i  (jmp_run),
        .tc_o  (jmp_tc)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            facing_q <= 1'b0;
            frame_q  <= 2'd0;
            motion_q <= MOT_IDLE;
        end else begin
            state_q  <= state_d;
            facing_q <= facing_d;
            frame_q  <= frame_d;
            motion_q <= motion_of(state_d, facing_d, frame_d);
        end
    end

    assign motion = motion_q;

endmodule

// File: tb/tb_sprite_state.sv
// tb/tb_sprite_state.sv - scoreboard bench for sprite_state with a behavioural reference model
module tb_sprite_state;

    localparam int FD = 4;
    localparam int JC = 8;

    logic       Clk;
    logic       Reset;
    logic [7:0] Keycode;
    logic [3:0] motion;

    int total = 0;
    int bad   = 0;

    int exp_q[$];
    string name_q[$];

    // Reference model: mode 0 idle, 1 walk, 2 jump
    int m_mode;
    int m_face;
    int m_walk_t;   // edges spent in the current walk
    int m_jage;     // edges spent in the current jump

    sprite_state #(.FRAME_DIV(FD), .JUMP_CYCLES(JC)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Keycode (Keycode),
        .motion  (motion)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_face = 0; m_walk_t = 0; m_jage = 0;
    endtask

    function automatic int model_motion();
        if (m_mode == 1) return 2 + 4 * m_face + (m_walk_t / FD) % 4;
        if (m_mode == 2) return 10 + m_face;
        return m_face;
    endfunction

    task automatic model_step(input int key);
        int from;
        int f;
        if (m_mode == 2 && m_jage < JC - 1) begin
            m_jage++;
            return;
        end
        from = (m_mode == 2) ? 0 : m_mode;
        if (key == 80 || key == 79) begin
            f = (key == 80) ? 1 : 0;
            if (from == 1 && m_face == f) begin
                m_walk_t++;
            end else begin
                m_mode = 1; m_face = f; m_walk_t = 0;
            end
        end else if (key == 82) begin
            m_mode = 2; m_jage = 0;
        end else begin
            m_mode = 0;
        end
    endtask

    // Apply a key for n edges; the model's prediction for each edge is queued.
    task automatic hold(input int key, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Keycode = key[7:0];
            model_step(key);
            exp_q.push_back(model_motion());
            name_q.push_back(nm);
        end
    endtask

    task automatic now_is(input string nm, input int exp);
        @(posedge Clk);
        #2;
        check(nm, int'(motion), exp);
    endtask

    // Monitor: motion is presented every edge; compare against queued prediction.
    initial begin
        int e;
        string nm;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, int'(motion), e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int key;
        int pick;
        int runlen;
        int guard;

        model_reset();
        Reset   = 1'b1;
        Keycode = 8'd0;
        #3;
        check("reset_async", int'(motion), 0);
        @(posedge Clk);
        #2;
        check("reset_held", int'(motion), 0);
        @(negedge Clk);
        Reset = 1'b0;
        now_is("after_reset", 0);

        // Walk left with frame wrap
        hold(80, 1, "walk_l");
        now_is("walk_l_f0", 6);
        hold(80, 3, "walk_l");
        now_is("walk_l_f0_hold", 6);
        hold(80, 1, "walk_l");
        now_is("walk_l_f1", 7);
        hold(80, 4, "walk_l");
        now_is("walk_l_f2", 8);
        hold(80, 4, "walk_l");
        now_is("walk_l_f3", 9);
        hold(80, 4, "walk_l");
        now_is("walk_l_wrap", 6);

        // Left -> right -> none
        hold(80, 5, "rev_lr");
        hold(79, 1, "rev_lr");
        now_is("rev_lr_restart", 2);
        hold(79, 4, "rev_lr");
        hold(0, 5, "rev_lr");
        now_is("rev_lr_idle", 0);

        // Right -> left -> none
        hold(79, 5, "rev_rl");
        hold(80, 1, "rev_rl");
        now_is("rev_rl_restart", 6);
        hold(80, 4, "rev_rl");
        hold(0, 5, "rev_rl");
        now_is("rev_rl_idle", 1);

        // Jump facing left, keys ignored mid-jump
        hold(82, 1, "jump_l");
        now_is("jump_l_start", 11);
        hold(80, 2, "jump_l");
        hold(79, 2, "jump_l");
        hold(4, 2, "jump_l");
        hold(0, 1, "jump_l");
        now_is("jump_l_last", 11);
        hold(0, 1, "jump_l");
        now_is("jump_l_land", 1);

        // Unknown key while walking right, then continuous jumping
        hold(79, 3, "unk");
        hold(4, 1, "unk");
        now_is("unk_idle", 0);
        hold(82, 3 * JC + 3, "rejump");
        now_is("rejump_steady", 10);
        hold(0, 1, "rejump");
        hold(0, JC, "rejump");

        // Reset mid-walk is immediate
        hold(80, 6, "pre_rst");
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("reset_mid_walk", int'(motion), 0);
        @(posedge Clk);
        #2;
        check("reset_hold_key", int'(motion), 0);
        @(negedge Clk);
        Keycode = 8'd0;
        Reset   = 1'b0;
        model_reset();

        // Reset mid-jump
        hold(82, 3, "pre_rst_j");
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("reset_mid_jump", int'(motion), 0);
        @(negedge Clk);
        Keycode = 8'd0;
        Reset   = 1'b0;
        model_reset();

        // Randomised runs
        for (int r = 0; r < 300; r++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2: key = 80;
                3, 4, 5: key = 79;
                6:       key = 82;
                7:       key = 0;
                8:       key = 4;
                default: key = $urandom_range(0, 255);
            endcase
            runlen = $urandom_range(1, 12);
            hold(key, runlen, "rand");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge Clk);
            guard++;
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
